// File: rtl/add_ctrl_fsm_pkg.sv
// add_ctrl_fsm_pkg
//   Shared definitions for the adder control unit: state encodings, datapath
//   select/op constants, the bundled control-output struct and the
//   state-to-output decode used by the controller.
package add_ctrl_fsm_pkg;

  typedef logic [2:0] state_t;

  // Binary state encodings, kept as plain constants for older tools.
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LD_FIRST = 3'd1;
  localparam state_t ST_MOV      = 3'd2;
  localparam state_t ST_LD_NEXT  = 3'd3;
  localparam state_t ST_ACC      = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  // ALU operation and REG1 source select.
  localparam logic OP_PASS = 1'b0;
  localparam logic OP_ADD  = 1'b1;
  localparam logic SEL_DIN = 1'b1;
  localparam logic SEL_FB  = 1'b0;

  // Moore control outputs; ld_1_en is gated with operand_valid in the top.
  typedef struct packed {
    logic operand_ready;
    logic sel_1;
    logic ld_1_en;
    logic ld_2;
    logic op;
    logic en;
    logic busy;
    logic done;
  } ctrl_t;

  // Decode a state into its Moore control word.
  function automatic ctrl_t decode_ctrl(input state_t st);
    ctrl_t c;
    c       = '0;
    c.sel_1 = SEL_FB;
    c.op    = OP_PASS;
    case (st)
      ST_IDLE: begin
        c = '0;
      end
      ST_LD_FIRST, ST_LD_NEXT: begin
        c.operand_ready = 1'b1;
        c.sel_1         = SEL_DIN;
        c.ld_1_en       = 1'b1;
        c.busy          = 1'b1;
      end
      ST_MOV: begin
        c.op   = OP_PASS;
        c.en   = 1'b1;
        c.ld_2 = 1'b1;
        c.busy = 1'b1;
      end
      ST_ACC: begin
        c.op   = OP_ADD;
        c.en   = 1'b1;
        c.ld_2 = 1'b1;
        c.busy = 1'b1;
      end
      ST_DONE: begin
        c.op   = OP_ADD;
        c.en   = 1'b1;
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/add_ctrl_fsm.sv
// add_ctrl_fsm
//   Sequences the REG1/REG2/ALU datapath to sum NUM_OPS 4-bit operands taken
//   over a valid/ready handshake, then holds the result with done until ack.
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, ACTIVE HIGH despite the legacy name
//   start         job request (IDLE only)
//   operand_valid data_in carries an operand this cycle
//   ack           consumer took the result (DONE only)
//   operand_ready controller loads data_in this cycle if operand_valid
//   sel_1         REG1 source: 1 = data_in, 0 = data_out
//   ld_1, ld_2    REG1 / REG2 load enables (ld_1 is Mealy on operand_valid)
//   op            ALU op: 0 = pass REG1, 1 = REG1 + REG2
//   en            datapath output enable
//   busy, done    job in progress / data_out holds the final sum
module add_ctrl_fsm
  import add_ctrl_fsm_pkg::*;
#(
  parameter int NUM_OPS = 2,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic operand_valid,
  input  logic ack,
  output logic operand_ready,
  output logic sel_1,
  output logic ld_1,
  output logic ld_2,
  output logic op,
  output logic en,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  ctrl_t            ctrl_r;
  logic             xfer_s;

  // ctrl_r always matches state_r, so its ready bit qualifies the transfer.
  assign xfer_s = operand_valid & ctrl_r.operand_ready;

  // Next-state and operand-counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LD_FIRST;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LD_FIRST: begin
        if (xfer_s) begin
          state_next_s = ST_MOV;
          cnt_next_s   = CNT_W'(1);
        end else begin
          state_next_s = ST_LD_FIRST;
        end
      end
      ST_MOV: begin
        state_next_s = ST_LD_NEXT;
      end
      ST_LD_NEXT: begin
        if (!xfer_s) begin
          state_next_s = ST_LD_NEXT;
        end else if (cnt_r == LAST_CNT) begin
          // Last operand sits in REG1; DONE adds it to REG2 combinationally.
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACC;
          cnt_next_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_ACC: begin
        state_next_s = ST_LD_NEXT;
      end
      ST_DONE: begin
        // A start arriving with ack is dropped, not queued.
        if (ack) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, counter and registered Moore outputs (decoded from next state).
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ctrl_r  <= decode_ctrl(state_next_s);
    end
  end

  assign operand_ready = ctrl_r.operand_ready;
  assign sel_1         = ctrl_r.sel_1;
  assign ld_1          = ctrl_r.ld_1_en & operand_valid;
  assign ld_2          = ctrl_r.ld_2;
  assign op            = ctrl_r.op;
  assign en            = ctrl_r.en;
  assign busy          = ctrl_r.busy;
  assign done          = ctrl_r.done;

endmodule

// File: tb/tb_add_ctrl_fsm.sv
// tb_add_ctrl_fsm
//   Two controller instances (NUM_OPS = 2 and 4), each driving a small
//   behavioural REG1/REG2/ALU datapath. Expected sums are queued when a job
//   is issued and compared against data_out when done rises.
module tb_add_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [1:0] start;
  logic [1:0] valid;
  logic [1:0] ack;
  logic [3:0] din  [2];
  logic [3:0] dout [2];
  logic       rdy  [2];
  logic       sel  [2];
  logic       ld1  [2];
  logic       ld2  [2];
  logic       opo  [2];
  logic       eno  [2];
  logic       bsy  [2];
  logic       dne  [2];

  int         total   = 0;
  int         bad     = 0;
  int         ld1_cnt = 0;
  logic [3:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] r1, r2, f;

    add_ctrl_fsm #(.NUM_OPS((g == 0) ? 2 : 4), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst), .start(start[g]), .operand_valid(valid[g]),
      .ack(ack[g]), .operand_ready(rdy[g]), .sel_1(sel[g]), .ld_1(ld1[g]),
      .ld_2(ld2[g]), .op(opo[g]), .en(eno[g]), .busy(bsy[g]), .done(dne[g])
    );

    // Upstream datapath: f = op ? REG1 + REG2 : REG1, gated by en.
    assign f       = opo[g] ? (r1 + r2) : r1;
    assign dout[g] = eno[g] ? f : 4'd0;

    always_ff @(posedge clk) begin
      if (ld1[g]) r1 <= sel[g] ? din[g] : dout[g];
      if (ld2[g]) r2 <= dout[g];
    end
  end

  always @(posedge clk) if (ld1[1]) ld1_cnt <= ld1_cnt + 1;

  function automatic logic [7:0] outs(input int g);
    return {rdy[g], sel[g], ld1[g], ld2[g], opo[g], eno[g], bsy[g], dne[g]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int g, input logic [3:0] v, input int gap);
    int n;
    n = 0;
    while (!rdy[g] && n < 20) begin tick(); n++; end
    chk("rdy_wait", {7'd0, rdy[g]}, 8'd1);
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("rdy_hold", {7'd0, rdy[g]}, 8'd1);
      chk("ld1_no_valid", {7'd0, ld1[g]}, 8'd0);
    end
    din[g] = v; valid[g] = 1'b1; #1;
    chk("ld1_mealy", {7'd0, ld1[g]}, 8'd1);
    tick();
    valid[g] = 1'b0; #1;
    chk("rdy_after_xfer", {7'd0, rdy[g]}, 8'd0);
  endtask

  task automatic wait_done(input int g);
    int n;
    logic [3:0] e;
    n = 0;
    while (!dne[g] && n < 40) begin tick(); n++; end
    chk("done_wait", {7'd0, dne[g]}, 8'd1);
    chk("sb_depth", {7'd0, exp_q.size() != 0}, 8'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sum", {4'd0, dout[g]}, {4'd0, e});
    end
  endtask

  task automatic do_ack(input int g);
    ack[g] = 1'b1;
    tick();
    ack[g] = 1'b0;
    chk("idle_after_ack", outs(g), 8'h00);
  endtask

  task automatic run_job(input int g, input int n, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] a3, input int gap);
    logic [3:0] ops [4];
    logic [3:0] s;
    ops[0] = a0; ops[1] = a1; ops[2] = a2; ops[3] = a3;
    s = 4'd0;
    for (int i = 0; i < n; i++) s = s + ops[i];
    exp_q.push_back(s);
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    for (int i = 0; i < n; i++) feed(g, ops[i], gap);
    wait_done(g);
  endtask

  initial begin
    int c0;
    rst = 1'b1; start = 2'b11; valid = 2'b11; ack = 2'b00;
    din[0] = 4'd0; din[1] = 4'd0;
    #12;
    chk("reset_outs0", outs(0), 8'h00);
    chk("reset_outs1", outs(1), 8'h00);
    start = 2'b00; valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();

    // Job 1: 3 + 5, valid held, exact per-cycle sequence.
    exp_q.push_back(4'd8);
    start[0] = 1'b1; valid[0] = 1'b1; din[0] = 4'd3;
    tick();
    start[0] = 1'b0;
    chk("c1_ld_first", outs(0), 8'b1110_0010);
    tick();
    din[0] = 4'd5;
    chk("c2_mov_no_ld1", outs(0), 8'b0001_0110);
    tick();
    chk("c3_ld_next", outs(0), 8'b1110_0010);
    tick();
    valid[0] = 1'b0;
    chk("c4_done", outs(0), 8'b0000_1111);
    wait_done(0);
    do_ack(0);

    // Job 2: 9 + 9 wraps to 2, result held without ack.
    run_job(0, 2, 4'd9, 4'd9, 4'd0, 4'd0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_done", {7'd0, dne[0]}, 8'd1);
      chk("hold_value", {4'd0, dout[0]}, 8'd2);
    end
    do_ack(0);

    // Job 3: NUM_OPS = 4 with two-cycle bubbles before each operand.
    c0 = ld1_cnt;
    run_job(1, 4, 4'd1, 4'd2, 4'd3, 4'd4, 2);
    chk("ld1_pulses", 8'(ld1_cnt - c0), 8'd4);
    do_ack(1);

    // Job 4: start in LD_NEXT and DONE ignored; start+ack in DONE not queued.
    exp_q.push_back(4'd13);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    feed(0, 4'd6, 0);
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("start_in_ld_next", outs(0), 8'b1100_0010);
    feed(0, 4'd7, 0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("start_in_done", outs(0), 8'b0000_1111);
    wait_done(0);
    start[0] = 1'b1; ack[0] = 1'b1;
    tick();
    start[0] = 1'b0; ack[0] = 1'b0;
    chk("start_ack_idle", outs(0), 8'h00);
    tick();
    chk("start_not_queued", outs(0), 8'h00);

    // Reset mid-ACC on the 4-operand instance clears outputs asynchronously.
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    feed(1, 4'd5, 0);
    feed(1, 4'd6, 0);
    chk("in_acc", outs(1), 8'b0001_1110);
    rst = 1'b1; #1;
    chk("async_rst1", outs(1), 8'h00);
    chk("async_rst0", outs(0), 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", outs(1), 8'h00);
    run_job(0, 2, 4'd2, 4'd2, 4'd0, 4'd0, 0);
    do_ack(0);
    run_job(1, 4, 4'd15, 4'd15, 4'd15, 4'd15, 0);
    do_ack(1);

    // ack in IDLE and in LD_FIRST has no effect.
    exp_q.push_back(4'd8);
    ack[0] = 1'b1;
    tick();
    chk("ack_in_idle", outs(0), 8'h00);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    chk("ack_in_ld_first", outs(0), 8'b1100_0010);
    ack[0] = 1'b0;
    feed(0, 4'd4, 0);
    feed(0, 4'd4, 0);
    wait_done(0);
    do_ack(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
